// File: rtl/cpu_control_unit.sv
// Hardwired multi-cycle controller for the downsampling CPU datapath.
// Sequences fetch, IR load, decode and execute, and drives every datapath strobe.
module cpu_control_unit #(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  Dec_IN,
    input  logic        z_flag,
    input  logic        finish_signal,
    output logic [2:0]  Op,
    output logic [3:0]  shift,
    output logic        fetch,
    output logic        Decode,
    output logic        PC1,
    output logic        Read_AC,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic [1:0]  Ins_Con,
    output logic [14:0] Read_RL,
    output logic [17:0] Write_RL,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    localparam logic [2:0] OP_PASSA = 3'd0;
    localparam logic [2:0] OP_PASSB = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_SHR   = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LOADIR, S_DECODE, S_EXEC,
        S_MEMRD, S_LDAC, S_MEMWR, S_HALT
    } state_t;

    state_t     state, state_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic [7:0] opcode;
    logic [3:0] r;
    logic       op_legal;

    assign r = opcode[3:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            opcode   <= 8'd0;
            illegal  <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (state == S_DECODE)
                opcode <= Dec_IN;
            if (state == S_EXEC && !op_legal)
                illegal <= 1'b1;
        end
    end

    // Register operands above R11 and any unlisted code count as illegal.
    always_comb begin
        op_legal = 1'b0;
        case (opcode[7:4])
            4'h0:                   op_legal = (r == 4'h0);
            4'h1, 4'h2, 4'h3, 4'h4: op_legal = (r <= 4'd11);
            4'h5:                   op_legal = 1'b1;
            4'h6, 4'h7, 4'h9, 4'hA: op_legal = (r == 4'h0);
            4'h8:                   op_legal = (r <= 4'h1);
            4'hF:                   op_legal = (r == 4'hF);
            default:                op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = 4'd0;
        case (state)
            S_IDLE:   if (start) state_next = S_FETCH;
            S_FETCH:  state_next = finish_signal ? S_HALT : S_LOADIR;
            S_LOADIR: state_next = S_DECODE;
            S_DECODE: state_next = S_EXEC;
            S_EXEC: begin
                if (!op_legal)
                    state_next = S_HALT;
                else if (opcode == 8'h60)
                    state_next = S_MEMRD;
                else if (opcode == 8'h70)
                    state_next = S_MEMWR;
                else if (opcode == 8'hFF)
                    state_next = S_HALT;
                else
                    state_next = S_FETCH;
            end
            S_MEMRD: begin
                if (wait_cnt == 4'(MEM_WAIT - 1))
                    state_next = S_LDAC;
                else
                    wait_cnt_next = wait_cnt + 4'd1;
            end
            S_LDAC:   state_next = S_FETCH;
            S_MEMWR: begin
                if (wait_cnt == 4'(MEM_WAIT - 1))
                    state_next = S_FETCH;
                else
                    wait_cnt_next = wait_cnt + 4'd1;
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_IDLE;
        endcase
    end

    // Moore outputs; only JZ looks at a live input (z_flag) during EXEC.
    always_comb begin
        Op        = OP_PASSA;
        shift     = 4'd0;
        fetch     = 1'b0;
        Decode    = 1'b0;
        PC1       = 1'b0;
        Read_AC   = 1'b0;
        Mem_Read  = 1'b0;
        Mem_Write = 1'b0;
        Ins_Con   = 2'b00;
        Read_RL   = 15'd0;
        Write_RL  = 18'd0;
        case (state)
            S_FETCH:  fetch = 1'b1;
            S_LOADIR: begin
                Read_RL[12] = 1'b1;
                Op          = OP_PASSB;
                Write_RL[14] = 1'b1;
            end
            S_DECODE: begin
                Decode = 1'b1;
                PC1    = 1'b1;
            end
            S_EXEC: begin
                if (op_legal) begin
                    case (opcode[7:4])
                        4'h1: begin
                            Read_RL  = 15'(1) << r;
                            Op       = OP_PASSB;
                            Write_RL = 18'd1;
                        end
                        4'h2: begin
                            Read_AC  = 1'b1;
                            Write_RL = 18'(1) << (5'(r) + 5'd1);
                        end
                        4'h3, 4'h4: begin
                            Read_AC  = 1'b1;
                            Read_RL  = 15'(1) << r;
                            Op       = (opcode[7:4] == 4'h3) ? OP_ADD : OP_SUB;
                            Write_RL = 18'd1;
                        end
                        4'h5: begin
                            Read_AC  = 1'b1;
                            shift    = r;
                            Op       = OP_SHR;
                            Write_RL = 18'd1;
                        end
                        4'h7: begin
                            Read_AC      = 1'b1;
                            Write_RL[16] = 1'b1;
                        end
                        4'h8: if (r == 4'h0 || z_flag) Ins_Con = 2'b10;
                        4'h9: Ins_Con = 2'b01;
                        4'hA: begin
                            Read_AC      = 1'b1;
                            Write_RL[15] = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_MEMRD:  Mem_Read = 1'b1;
            S_LDAC: begin
                Read_RL[14] = 1'b1;
                Op          = OP_PASSB;
                Write_RL[0] = 1'b1;
            end
            S_MEMWR:  Mem_Write = 1'b1;
            default: ;
        endcase
    end

    assign busy   = (state != S_IDLE) && (state != S_HALT);
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit; every output is packed
// into one vector per cycle and compared against hand-computed expectations.
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  Dec_IN;
    logic        z_flag;
    logic        finish_signal;
    logic [2:0]  Op;
    logic [3:0]  shift;
    logic        fetch, Decode, PC1, Read_AC, Mem_Read, Mem_Write;
    logic [1:0]  Ins_Con;
    logic [14:0] Read_RL;
    logic [17:0] Write_RL;
    logic        busy, halted, illegal;

    int checkCount = 0;
    int errorCount = 0;

    cpu_control_unit #(.MEM_WAIT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .Dec_IN(Dec_IN),
        .z_flag(z_flag), .finish_signal(finish_signal),
        .Op(Op), .shift(shift), .fetch(fetch), .Decode(Decode), .PC1(PC1),
        .Read_AC(Read_AC), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
        .Ins_Con(Ins_Con), .Read_RL(Read_RL), .Write_RL(Write_RL),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // strobes = {fetch, Decode, PC1, Read_AC, Mem_Read, Mem_Write}; st = {busy, halted, illegal}
    function automatic logic [63:0] pk(input logic [5:0] strobes, input logic [1:0] ic,
                                       input logic [2:0] op, input logic [3:0] sh,
                                       input logic [14:0] rr, input logic [17:0] wr,
                                       input logic [2:0] st);
        return {13'd0, strobes, ic, op, sh, rr, wr, st};
    endfunction

    function automatic logic [63:0] observed();
        return pk({fetch, Decode, PC1, Read_AC, Mem_Read, Mem_Write}, Ins_Con, Op, shift,
                  Read_RL, Write_RL, {busy, halted, illegal});
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [63:0] vIdle, vFetch, vLoadir, vDecode, vBusy, vHalt, vIllegal, vMemRd, vMemWr, vLdac;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        #3;
        checkOutput("reset", observed(), vIdle);
        reset = 1'b0;
    endtask

    // Runs FETCH/LOADIR/DECODE for one opcode and leaves the bench sampling in EXEC.
    task automatic applyStimulus(input logic [7:0] op, input logic z);
        Dec_IN = op;
        z_flag = z;
        cyc();
        start = 1'b0;
        checkOutput($sformatf("fetch %h", op), observed(), vFetch);
        cyc();
        checkOutput($sformatf("loadir %h", op), observed(), vLoadir);
        cyc();
        checkOutput($sformatf("decode %h", op), observed(), vDecode);
        cyc();
    endtask

    task automatic expectExec(input logic [7:0] op, input logic [63:0] exp);
        checkOutput($sformatf("exec %h", op), observed(), exp);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vIdle    = 64'd0;
        vFetch   = pk(6'b100000, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b100);
        vLoadir  = pk(6'b000000, 2'b00, 3'd1, 4'd0, 15'h1000, 18'h04000, 3'b100);
        vDecode  = pk(6'b011000, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b100);
        vBusy    = pk(6'b000000, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b100);
        vHalt    = pk(6'b000000, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b010);
        vIllegal = pk(6'b000000, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b011);
        vMemRd   = pk(6'b000010, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b100);
        vMemWr   = pk(6'b000001, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b100);
        vLdac    = pk(6'b000000, 2'b00, 3'd1, 4'd0, 15'h4000, 18'h00001, 3'b100);

        reset = 1'b1; start = 1'b0; Dec_IN = 8'h00; z_flag = 1'b0; finish_signal = 1'b0;

        // Program 0x13, 0x35, 0xFF: halted after the 12th cycle, start ignored afterwards.
        applyReset();
        start = 1'b1;
        applyStimulus(8'h13, 1'b0);
        expectExec(8'h13, pk(6'b000000, 2'b00, 3'd1, 4'd0, 15'h0008, 18'h00001, 3'b100));
        applyStimulus(8'h35, 1'b0);
        expectExec(8'h35, pk(6'b000100, 2'b00, 3'd2, 4'd0, 15'h0020, 18'h00001, 3'b100));
        applyStimulus(8'hFF, 1'b0);
        expectExec(8'hFF, vBusy);
        cyc();
        checkOutput("halt after FF", observed(), vHalt);
        start = 1'b1;
        cyc(); cyc();
        start = 1'b0;
        checkOutput("halt ignores start", observed(), vHalt);

        // LOAD, STORE, jumps, shifts and the remaining classes back to back.
        applyReset();
        start = 1'b1;
        applyStimulus(8'h60, 1'b0);
        expectExec(8'h60, vBusy);
        cyc(); checkOutput("memrd 1", observed(), vMemRd);
        cyc(); checkOutput("memrd 2", observed(), vMemRd);
        cyc(); checkOutput("ldac", observed(), vLdac);
        applyStimulus(8'h70, 1'b0);
        expectExec(8'h70, pk(6'b000100, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h10000, 3'b100));
        cyc(); checkOutput("memwr 1", observed(), vMemWr);
        cyc(); checkOutput("memwr 2", observed(), vMemWr);
        applyStimulus(8'h81, 1'b0);
        expectExec(8'h81, vBusy);
        applyStimulus(8'h81, 1'b1);
        expectExec(8'h81, pk(6'b000000, 2'b10, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b100));
        applyStimulus(8'h80, 1'b0);
        expectExec(8'h80, pk(6'b000000, 2'b10, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b100));
        applyStimulus(8'h90, 1'b0);
        expectExec(8'h90, pk(6'b000000, 2'b01, 3'd0, 4'd0, 15'h0000, 18'h00000, 3'b100));
        applyStimulus(8'h53, 1'b0);
        expectExec(8'h53, pk(6'b000100, 2'b00, 3'd4, 4'd3, 15'h0000, 18'h00001, 3'b100));
        applyStimulus(8'h50, 1'b0);
        expectExec(8'h50, pk(6'b000100, 2'b00, 3'd4, 4'd0, 15'h0000, 18'h00001, 3'b100));
        applyStimulus(8'h2B, 1'b0);
        expectExec(8'h2B, pk(6'b000100, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h01000, 3'b100));
        applyStimulus(8'h4B, 1'b0);
        expectExec(8'h4B, pk(6'b000100, 2'b00, 3'd3, 4'd0, 15'h0800, 18'h00001, 3'b100));
        applyStimulus(8'hA0, 1'b0);
        expectExec(8'hA0, pk(6'b000100, 2'b00, 3'd0, 4'd0, 15'h0000, 18'h08000, 3'b100));
        applyStimulus(8'h00, 1'b0);
        expectExec(8'h00, vBusy);
        applyStimulus(8'hFF, 1'b0);
        cyc();
        checkOutput("halt after program 2", observed(), vHalt);

        // Illegal register operand and an unlisted opcode both halt with illegal set.
        applyReset();
        start = 1'b1;
        applyStimulus(8'h1C, 1'b0);
        expectExec(8'h1C, vBusy);
        cyc();
        checkOutput("illegal 1C", observed(), vIllegal);
        start = 1'b1;
        cyc(); cyc();
        start = 1'b0;
        checkOutput("illegal ignores start", observed(), vIllegal);
        applyReset();
        start = 1'b1;
        applyStimulus(8'hB3, 1'b0);
        expectExec(8'hB3, vBusy);
        cyc();
        checkOutput("illegal B3", observed(), vIllegal);

        // finish_signal during FETCH goes straight to HALT.
        applyReset();
        start = 1'b1;
        finish_signal = 1'b1;
        cyc();
        start = 1'b0;
        checkOutput("finish fetch", observed(), vFetch);
        cyc();
        finish_signal = 1'b0;
        checkOutput("finish halt", observed(), vHalt);

        // Asynchronous reset in the first Mem_Write cycle, then a normal restart.
        applyReset();
        start = 1'b1;
        applyStimulus(8'h70, 1'b0);
        cyc();
        checkOutput("memwr before reset", observed(), vMemWr);
        #2 reset = 1'b1;
        #1 checkOutput("async reset", observed(), vIdle);
        #1 reset = 1'b0;
        start = 1'b1;
        applyStimulus(8'h13, 1'b0);
        expectExec(8'h13, pk(6'b000000, 2'b00, 3'd1, 4'd0, 15'h0008, 18'h00001, 3'b100));

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
